vga_timing_controller: RTL and testbench

- Sequencer for the pixel generator: produces the 640x480@60 Hz raster scan (pix_x, pix_y), sync pulses and video_on.
- Owns ctrl_rgb, the colour-select register feeding the pixel generator.
- ctrl_rgb changes only at frame boundaries, so the generator never shows a colour change mid-frame.
- Sits between the board clock and Generador_Pixeles; its hsync/vsync go straight to the VGA connector.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/vga_pixel_tick.sv | 35 +++
 rtl/vga_timing_controller.sv | 134 +++++++++++++
 tb/tb_vga_timing_controller.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 Hz timing constants and helpers, used by the timing
// controller and the pixel generator.
package vga_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned RGB_W       = 3;
    localparam int unsigned CLK_DIV_DEF = 2;

    localparam int unsigned H_VIS  = 640;
    localparam int unsigned H_FP   = 16;
    localparam int unsigned H_SYNC = 96;
    localparam int unsigned H_BP   = 48;
    localparam int unsigned V_VIS  = 480;
    localparam int unsigned V_FP   = 10;
    localparam int unsigned V_SYNC = 2;
    localparam int unsigned V_BP   = 33;

    localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Half-open window test; done in 32 bits so an end bound of 1024 still works.
    function automatic logic in_range(input logic [COORD_W-1:0] v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (32'(v) >= lo) && (32'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock divider: raises the advance strobe every CLK_DIV clocks and
// registers it as the externally visible pixel tick.
module vga_pixel_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic CLK,
    input  logic RESET,
    output logic o_advance,
    output logic o_p_tick
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_p_tick;
    logic             w_advance;

    assign w_advance = (r_div_cnt == DIV_LAST);
    assign o_advance = w_advance;
    assign o_p_tick  = r_p_tick;

    // Divider count and registered tick
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_div_cnt <= {DIV_W{1'b0}};
            r_p_tick  <= 1'b0;
        end else begin
            r_p_tick  <= w_advance;
            r_div_cnt <= w_advance ? {DIV_W{1'b0}} : (r_div_cnt + DIV_ONE);
        end
    end

endmodule

// File: rtl/vga_timing_controller.sv
// Raster sequencer: pixel/line counters, registered sync/blank decode and the
// frame-synchronous colour-select register for the pixel generator.
module vga_timing_controller #(
    parameter int unsigned CLK_DIV = vga_pkg::CLK_DIV_DEF,
    parameter int unsigned H_VIS   = vga_pkg::H_VIS,
    parameter int unsigned H_FP    = vga_pkg::H_FP,
    parameter int unsigned H_SYNC  = vga_pkg::H_SYNC,
    parameter int unsigned H_BP    = vga_pkg::H_BP,
    parameter int unsigned V_VIS   = vga_pkg::V_VIS,
    parameter int unsigned V_FP    = vga_pkg::V_FP,
    parameter int unsigned V_SYNC  = vga_pkg::V_SYNC,
    parameter int unsigned V_BP    = vga_pkg::V_BP
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [vga_pkg::RGB_W-1:0]    sw_rgb,
    input  logic                         auto_mode,
    output logic                         p_tick,
    output logic [vga_pkg::COORD_W-1:0]  pix_x,
    output logic [vga_pkg::COORD_W-1:0]  pix_y,
    output logic                         hsync,
    output logic                         vsync,
    output logic                         video_on,
    output logic                         frame_start,
    output logic [vga_pkg::RGB_W-1:0]    ctrl_rgb
);

    import vga_pkg::*;

    localparam int unsigned H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_START = H_VIS + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_VIS + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST    = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [RGB_W-1:0]   RGB_ONE   = RGB_W'(1);

    logic                 w_advance;
    logic                 w_wrap;
    logic [COORD_W-1:0]   w_x_next;
    logic [COORD_W-1:0]   w_y_next;

    logic [COORD_W-1:0]   r_x;
    logic [COORD_W-1:0]   r_y;
    logic                 r_hsync;
    logic                 r_vsync;
    logic                 r_video_on;
    logic                 r_frame_start;
    logic [RGB_W-1:0]     r_ctrl_rgb;
    logic [RGB_W-1:0]     r_sw_meta;
    logic [RGB_W-1:0]     r_sw_sync;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .CLK       (CLK),
        .RESET     (RESET),
        .o_advance (w_advance),
        .o_p_tick  (p_tick)
    );

    // Next raster position; w_wrap marks the last pixel of the frame
    always_comb begin
        w_x_next = r_x;
        w_y_next = r_y;
        w_wrap   = 1'b0;
        if (r_x == H_LAST) begin
            w_x_next = {COORD_W{1'b0}};
            if (r_y == V_LAST) begin
                w_y_next = {COORD_W{1'b0}};
                w_wrap   = 1'b1;
            end else begin
                w_y_next = r_y + COORD_ONE;
            end
        end else begin
            w_x_next = r_x + COORD_ONE;
        end
    end

    // Decodes use the next position so they line up with pix_x/pix_y
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_x        <= {COORD_W{1'b0}};
            r_y        <= {COORD_W{1'b0}};
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else if (w_advance) begin
            r_x        <= w_x_next;
            r_y        <= w_y_next;
            r_hsync    <= ~in_range(w_x_next, H_SYNC_START, H_SYNC_END);
            r_vsync    <= ~in_range(w_y_next, V_SYNC_START, V_SYNC_END);
            r_video_on <= in_range(w_x_next, 0, H_VIS) && in_range(w_y_next, 0, V_VIS);
        end else begin
            r_x        <= r_x;
            r_y        <= r_y;
            r_hsync    <= r_hsync;
            r_vsync    <= r_vsync;
            r_video_on <= r_video_on;
        end
    end

    // Switch synchronizer, frame pulse and colour select (changes only at the wrap)
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_sw_meta     <= {RGB_W{1'b0}};
            r_sw_sync     <= {RGB_W{1'b0}};
            r_frame_start <= 1'b0;
            r_ctrl_rgb    <= {RGB_W{1'b0}};
        end else begin
            r_sw_meta     <= sw_rgb;
            r_sw_sync     <= r_sw_meta;
            r_frame_start <= w_advance & w_wrap;
            if (w_advance && w_wrap) begin
                r_ctrl_rgb <= auto_mode ? (r_ctrl_rgb + RGB_ONE) : r_sw_sync;
            end else begin
                r_ctrl_rgb <= r_ctrl_rgb;
            end
        end
    end

    assign pix_x       = r_x;
    assign pix_y       = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign frame_start = r_frame_start;
    assign ctrl_rgb    = r_ctrl_rgb;

endmodule

// File: tb/tb_vga_timing_controller.sv
// Bench for vga_timing_controller: a reduced raster run at CLK_DIV=2 and
// CLK_DIV=1 side by side, each compared every clock with a closed-form model.
module tb_vga_timing_controller;

    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 6;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [2:0] sw_rgb;
    logic       auto_mode;

    logic       p_tick [2];
    logic [9:0] pix_x [2];
    logic [9:0] pix_y [2];
    logic       hsync [2];
    logic       vsync [2];
    logic       video_on [2];
    logic       frame_start [2];
    logic [2:0] ctrl_rgb [2];

    int tests = 0;
    int fails = 0;
    int e [2];
    int fs_seen [2];
    int fs_exp [2];
    logic [2:0] ctrl_m [2];
    logic [2:0] sw_hist [2];

    vga_timing_controller #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_div2 (
        .CLK(CLK), .RESET(RESET), .sw_rgb(sw_rgb), .auto_mode(auto_mode),
        .p_tick(p_tick[0]), .pix_x(pix_x[0]), .pix_y(pix_y[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .video_on(video_on[0]),
        .frame_start(frame_start[0]), .ctrl_rgb(ctrl_rgb[0])
    );

    vga_timing_controller #(
        .CLK_DIV(1), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) u_dut_div1 (
        .CLK(CLK), .RESET(RESET), .sw_rgb(sw_rgb), .auto_mode(auto_mode),
        .p_tick(p_tick[1]), .pix_x(pix_x[1]), .pix_y(pix_y[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .video_on(video_on[1]),
        .frame_start(frame_start[1]), .ctrl_rgb(ctrl_rgb[1])
    );

    always #5 CLK = ~CLK;

    function automatic int div_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    // Pixel index reached after the model's count of post-reset clock edges
    function automatic int pix_n(input int d);
        return e[d] / div_of(d);
    endfunction

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    task automatic check_outputs(input int d);
        int n, x, y;
        logic tick_now;
        n = pix_n(d);
        x = n % HT;
        y = (n / HT) % VT;
        tick_now = (e[d] > 0) && (e[d] % div_of(d) == 0);
        chk("p_tick", d, p_tick[d], tick_now);
        chk("pix_x", d, pix_x[d], x);
        chk("pix_y", d, pix_y[d], y);
        chk("hsync", d, hsync[d], !((x >= HV + HF) && (x < HV + HF + HS)));
        chk("vsync", d, vsync[d], !((y >= VV + VF) && (y < VV + VF + VS)));
        chk("video_on", d, video_on[d], (x < HV) && (y < VV) && (n != 0));
        chk("frame_start", d, frame_start[d], tick_now && (n > 0) && (n % FT == 0));
        chk("ctrl_rgb", d, ctrl_rgb[d], ctrl_m[d]);
        if (frame_start[d] === 1'b1) fs_seen[d]++;
    endtask

    // One clock: capture inputs seen by the edge, advance the model, check both DUTs
    task automatic step();
        logic       rst_s;
        logic       auto_s;
        logic [2:0] sw_s;
        rst_s  = RESET;
        auto_s = auto_mode;
        sw_s   = sw_rgb;
        @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst_s) begin
                e[d]      = 0;
                ctrl_m[d] = 3'b000;
            end else begin
                e[d]++;
                if ((e[d] % div_of(d) == 0) && (pix_n(d) % FT == 0)) begin
                    ctrl_m[d] = auto_s ? (ctrl_m[d] + 3'd1) : sw_hist[1];
                    fs_exp[d]++;
                end
            end
        end
        if (rst_s) begin
            sw_hist[0] = 3'b000;
            sw_hist[1] = 3'b000;
        end else begin
            sw_hist[1] = sw_hist[0];
            sw_hist[0] = sw_s;
        end
        for (int d = 0; d < 2; d++) check_outputs(d);
    endtask

    task automatic wait_pos(input int x, input int y);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 4 * FT && !found; i++) begin
            step();
            if ((pix_n(0) % HT == x) && ((pix_n(0) / HT) % VT == y)) found = 1'b1;
        end
        chk("wait_pos", 0, found, 1);
    endtask

    initial begin
        RESET     = 1'b1;
        auto_mode = 1'b0;
        sw_rgb    = 3'b000;
        for (int d = 0; d < 2; d++) begin
            e[d] = 0; fs_seen[d] = 0; fs_exp[d] = 0; ctrl_m[d] = 3'b000;
        end
        sw_hist[0] = 3'b000;
        sw_hist[1] = 3'b000;

        repeat (3) step();

        // Auto colour stepping over nine frames of the slower DUT
        RESET     = 1'b0;
        auto_mode = 1'b1;
        repeat (9 * FT * 2 + 10) begin
            sw_rgb = 3'($urandom);
            step();
        end

        // Switch-follow mode with randomly changing switches
        auto_mode = 1'b0;
        repeat (4 * FT * 2) begin
            if ($urandom_range(0, 6) == 0) sw_rgb = 3'($urandom);
            step();
        end

        // Mid-frame switch change only lands at the next frame start
        sw_rgb = 3'b010;
        wait_pos(5, 3);
        sw_rgb = 3'b101;
        wait_pos(0, 0);
        chk("sw_applied_at_wrap", 0, ctrl_rgb[0], 3'b101);

        // One-cycle reset in the middle of a frame
        auto_mode = 1'b1;
        wait_pos(4, 3);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        chk("reset_x", 0, pix_x[0], 0);
        chk("reset_ctrl", 0, ctrl_rgb[0], 0);

        // Random auto/switch activity through the following frames
        repeat (3 * FT * 2) begin
            if ($urandom_range(0, 9) == 0) auto_mode = 1'($urandom);
            if ($urandom_range(0, 4) == 0) sw_rgb = 3'($urandom);
            step();
        end

        for (int d = 0; d < 2; d++) chk("frame_start_count", d, fs_seen[d], fs_exp[d]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
